param_instruction_ram: RTL
==========================

PARAM_INSTRUCTION_RAM -- requirements
Module: param_instruction_ram

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 10, meaning address width in bits.
REQ-003 The block SHALL provide parameter DEPTH, default 1024, meaning number of stored words, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL provide parameter NOP_WORD, default 32'h6C000000, meaning the fill and substitute word, which is the ISA Nop.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset; all ports are listed below.
REQ-006 Port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port fetch_enable, input, 1 bit: fetch request this cycle.
REQ-009 Port fetch_address, input, ADDR_W bits: fetch word address.
REQ-010 Port fetch_data, output, DATA_W bits: registered fetched word.
REQ-011 Port fetch_valid, output, 1 bit: fetch_data holds a new result.
REQ-012 Port write_valid, input, 1 bit: loader write request.
REQ-013 Port write_address, input, ADDR_W bits: loader write address.
REQ-014 Port write_data, input, DATA_W bits: loader write word.
REQ-015 Port write_ready, output, 1 bit: loader write accepted when high together with write_valid.
REQ-016 Port ready, output, 1 bit: initialisation is complete.
REQ-017 Port addr_error, output, 1 bit: one-cycle pulse on an out-of-range access.

Function
REQ-018 The FSM SHALL have two states, INIT and RUN; reset SHALL force INIT with init_count=0.
REQ-019 In INIT, the block SHALL write NOP_WORD to word init_count each cycle and increment init_count; after the write to word DEPTH-1, it SHALL enter RUN on the next edge, giving DEPTH cycles in INIT.
REQ-020 ready SHALL be high if and only if the state is RUN; write_ready SHALL equal ready.
REQ-021 In INIT, fetch_enable and write_valid SHALL be ignored, with no memory change and fetch_valid held at 0.
REQ-022 In RUN, a write SHALL be accepted when write_valid=1 and write_ready=1, updating the word at the same edge.
REQ-023 In RUN, a fetch SHALL have 1-cycle latency: a request at edge N produces fetch_data and fetch_valid=1 after edge N.
REQ-024 fetch_valid SHALL be 0 in any cycle following a cycle with no fetch, and fetch_data SHALL hold its last value.
REQ-025 When a fetch and an accepted write target the same in-range address in the same cycle, fetch_data SHALL return write_data (write-first bypass).
REQ-026 A fetch with fetch_address >= DEPTH SHALL return NOP_WORD with fetch_valid=1 and SHALL pulse addr_error.
REQ-027 An accepted write with write_address >= DEPTH SHALL be dropped without changing memory and SHALL pulse addr_error.
REQ-028 A simultaneous out-of-range fetch and write SHALL produce a single addr_error pulse.
REQ-029 Fetch and write in the same cycle to different addresses SHALL both complete.

Reset
REQ-030 On reset, the outputs SHALL be: fetch_data=NOP_WORD, fetch_valid=0, ready=0, write_ready=0, addr_error=0.
REQ-031 Reset asserted in RUN or mid-INIT SHALL restart INIT from word 0, and all prior contents SHALL be overwritten with NOP_WORD.
REQ-032 Memory contents SHALL be undefined only until INIT completes; no initial blocks SHALL be used for contents.

Structure
REQ-033 The state encoding (INIT, RUN) and the NOP_WORD default SHALL reside in the shared processor package.
REQ-034 The storage array SHALL be one sub-module, ram_array_1r1w, with a synchronous write port and a registered read port; the FSM, bypass and range checks SHALL stay in the top module.

Verification
REQ-035 Verification SHALL cover these directed scenarios:
- Reset, then wait DEPTH cycles -> ready rises exactly at cycle DEPTH; fetches of words 0, 511 and 1023 return 32'h6C000000.
- In RUN, write 32'h68A00001 to address 12, then fetch 12 on the next cycle -> fetch_data=32'h68A00001 one cycle later, fetch_valid=1.
- Fetch and write address 19 with 32'h70000000 in the same cycle -> fetch_data=32'h70000000 one cycle later.
- With DEPTH=20, fetch address 25 -> fetch_data=NOP_WORD and addr_error pulses once; write address 30 -> memory unchanged and addr_error pulses once.
- Write during INIT -> write_ready=0 and the word reads NOP after ready.
- Reset asserted at INIT count 500 and again in RUN after writes -> ready low for DEPTH cycles and all words read NOP.

Source files
------------

// File: rtl/param_instruction_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : param_instruction_ram_pkg
// Description : Shared processor definitions for the instruction RAM: the
//               ISA Nop word, controller state encoding and read-source tags.
// Revision    : 1.0 - initial release
// ============================================================================
package param_instruction_ram_pkg;

    // ISA Nop, used as the fill word and as the substitute for bad fetches
    localparam logic [31:0] c_NOP_WORD = 32'h6C00_0000;

    // Controller states: memory fill after reset, then normal operation
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Which registered source drives fetch_data
    typedef enum logic [1:0] {
        SRC_RAM    = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_NOP    = 2'd2
    } fetch_src_t;

    // True when a word address falls inside the populated part of the map
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_array_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : ram_array_1r1w
// Description : Plain storage array, one synchronous write port and one read
//               port with a registered output. No reset on contents.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_array_1r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // Index width actually needed to reach DEPTH entries
    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write and registered read; the read register holds when not enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr[c_IW-1:0]] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr[c_IW-1:0]];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/param_instruction_ram.sv
`default_nettype none
// ============================================================================
// Module      : param_instruction_ram
// Description : Instruction memory with power-up Nop fill, a loader write
//               port, a 1-cycle fetch port with write-first bypass and
//               out-of-range detection.
// Revision    : 1.0 - initial release
// ============================================================================
module param_instruction_ram
    import param_instruction_ram_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 10,
    parameter int                DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(c_NOP_WORD)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_enable,
    input  logic [ADDR_W-1:0] fetch_address,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              write_valid,
    input  logic [ADDR_W-1:0] write_address,
    input  logic [DATA_W-1:0] write_data,
    output logic              write_ready,
    output logic              ready,
    output logic              addr_error
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_init_count;
    logic [ADDR_W-1:0] w_init_count_nxt;

    fetch_src_t        r_fetch_src;
    logic [DATA_W-1:0] r_bypass_data;
    logic              r_fetch_valid;
    logic              r_addr_error;

    logic              w_run;
    logic              w_fetch_ok;
    logic              w_write_ok;
    logic              w_fetch_req;
    logic              w_write_req;
    logic              w_hit;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_run       = (r_state == ST_RUN);
    assign w_fetch_ok  = addr_in_range(32'(fetch_address), DEPTH);
    assign w_write_ok  = addr_in_range(32'(write_address), DEPTH);
    // Requests only count once the fill has finished
    assign w_fetch_req = w_run & fetch_enable;
    assign w_write_req = w_run & write_valid;
    // Same in-range word written and fetched together: return the new word
    assign w_hit       = w_fetch_req & w_write_req & w_fetch_ok & w_write_ok
                         & (fetch_address == write_address);

    // The fill sequence owns the write port in INIT, the loader owns it in RUN
    assign w_ram_we    = ~reset & (w_run ? (w_write_req & w_write_ok) : 1'b1);
    assign w_ram_waddr = w_run ? write_address : r_init_count;
    assign w_ram_wdata = w_run ? write_data    : NOP_WORD;
    assign w_ram_re    = ~reset & w_fetch_req & w_fetch_ok & ~w_hit;

    ram_array_1r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clock),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (fetch_address),
        .o_rdata (w_ram_rdata)
    );

    // Controller state and fill pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_init_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_init_count <= w_init_count_nxt;
        end
    end

    // Next state: step through every word once, then run
    always_comb begin
        w_state_nxt      = r_state;
        w_init_count_nxt = r_init_count;
        case (r_state)
            ST_INIT: begin
                w_init_count_nxt = r_init_count + ADDR_W'(1);
                if (r_init_count == c_LAST) begin
                    w_state_nxt      = ST_RUN;
                    w_init_count_nxt = r_init_count;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Fetch result tracking; sources only change on a fetch so data holds
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_src   <= SRC_NOP;
            r_bypass_data <= NOP_WORD;
            r_fetch_valid <= 1'b0;
            r_addr_error  <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_req;
            // One pulse even when both ports are out of range together
            r_addr_error  <= (w_fetch_req & ~w_fetch_ok)
                           | (w_write_req & ~w_write_ok);
            if (w_fetch_req) begin
                if (!w_fetch_ok) begin
                    r_fetch_src <= SRC_NOP;
                end else if (w_hit) begin
                    r_fetch_src   <= SRC_BYPASS;
                    r_bypass_data <= write_data;
                end else begin
                    r_fetch_src <= SRC_RAM;
                end
            end
        end
    end

    // Select the registered source for the fetch result
    always_comb begin
        fetch_data = NOP_WORD;
        case (r_fetch_src)
            SRC_RAM:    fetch_data = w_ram_rdata;
            SRC_BYPASS: fetch_data = r_bypass_data;
            default:    fetch_data = NOP_WORD;
        endcase
    end

    assign fetch_valid = r_fetch_valid;
    assign addr_error  = r_addr_error;
    assign ready       = w_run;
    assign write_ready = w_run;

endmodule
`default_nettype wire
